// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helpers.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input real clk_freq, input int baud);
    return int'($rtoi(clk_freq / real'(baud) + 0.5));
  endfunction

  function automatic int baud_half(input real clk_freq, input int baud);
    return baud_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO; the head is always visible on rd_data while not empty.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic               wr_ok;
  logic               rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

  // A pop frees the slot being written, so a full FIFO still accepts a write alongside a read.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_ptr[ADDR_BITS-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr[ADDR_BITS-1:0]];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, and queues good bytes in a FWFT FIFO.
//   state | meaning
//   IDLE  | line high, waiting for a falling edge
//   START | half a bit in, confirm the start bit is still low
//   DATA  | sample eight data bits, LSB first, one per bit period
//   STOP  | sample stop bit; high queues the byte, low flags a framing error
//   BREAK | line stuck low after a framing error, wait for it to go high
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter real CLK_FREQ       = 87.49091e6,
  parameter int  BAUD           = 115200,
  parameter int  FIFO_ADDR_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_i,
  input  logic                      rd_en_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      fifo_empty_o,
  output logic                      fifo_full_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int HALF = baud_half(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(UART_DATA_BITS);

  logic                      rx_meta;
  logic                      rxs;
  uart_rx_state_t            state;
  uart_rx_state_t            state_nxt;
  logic [CW-1:0]             cnt;
  logic                      tc;
  logic [BW-1:0]             bit_cnt;
  logic                      last_bit;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      load_half;
  logic                      load_div;
  logic                      bit_clr;
  logic                      shift_en;
  logic                      stop_good;
  logic                      stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign tc       = (cnt == '0);
  assign last_bit = (bit_cnt == BW'(UART_DATA_BITS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxs) state_nxt = START;
      START:   if (tc) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (tc && last_bit) state_nxt = STOP;
      STOP:    if (tc) state_nxt = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_div  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  load_half = 1'b1;
      START: begin
        bit_clr  = 1'b1;
        load_div = tc;
      end
      DATA: begin
        shift_en = tc;
        load_div = tc;
      end
      STOP: begin
        stop_good = tc && rxs;
        stop_bad  = tc && !rxs;
      end
      default: ;
    endcase
  end

  // Bit timer counts down to the next sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (load_half)     cnt <= CW'(HALF-1);
      else if (load_div) cnt <= CW'(DIV-1);
      else if (!tc)      cnt <= cnt - CW'(1);
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BW'(1);
      if (shift_en)      shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= stop_good && fifo_full_o && !rd_en_i;
    end
  end

  uart_rx_fifo #(
    .DATA_W    (UART_DATA_BITS),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (stop_good),
    .wr_data (shreg),
    .rd_en   (rd_en_i),
    .rd_data (data_o),
    .empty   (fifo_empty_o),
    .full    (fifo_full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level scoreboard of expected FIFO contents and error pulses.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV   = 10;
  localparam int HALF  = 5;
  localparam int DEPTH = 4;
  // Driver puts rx_i low just before edge P; two sync flops make T0 = P+2, stop sample at T0+HALF+9*DIV.
  localparam int STOP_OFS = 2 + HALF + 9 * DIV;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic       fifo_empty_o;
  logic       fifo_full_o;
  logic       frame_err_o;
  logic       overrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  logic [7:0] q[$];
  int         ev_kind[int];
  logic [7:0] ev_byte[int];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;

  uart_rx #(
    .CLK_FREQ       (1.0e6),
    .BAUD           (100000),
    .FIFO_ADDR_BITS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .rd_en_i      (rd_en_i),
    .data_o       (data_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_full_o  (fifo_full_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: frame outcomes are scheduled by the driver at the cycle the stop bit is sampled.
  initial begin
    int   e;
    int   sz;
    int   kind;
    logic rd;
    logic wr;
    forever begin
      @(posedge clk);
      e = cyc;
      cyc++;
      if (!rst_n) begin
        q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
      end else begin
        sz   = q.size();
        rd   = rd_en_i && (sz > 0);
        kind = ev_kind.exists(e) ? ev_kind[e] : 0;
        wr   = (kind == 1) && ((sz < DEPTH) || rd);
        exp_ovr  = (kind == 1) && !wr;
        exp_ferr = (kind == 2);
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(ev_byte[e]);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("empty", 32'(fifo_empty_o), 32'(q.size() == 0));
        check("full", 32'(fifo_full_o), 32'(q.size() == DEPTH));
        check("frame_err", 32'(frame_err_o), 32'(exp_ferr));
        check("overrun", 32'(overrun_o), 32'(exp_ovr));
        if (q.size() > 0) check("head", 32'(data_o), 32'(q[0]));
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drives one 10-bit frame from a negedge; abort_at >= 0 stops driving after that many cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
    int         st;
    int         n;
    logic [9:0] bits;
    st   = cyc;
    bits = {stop, d, 1'b0};
    n    = (abort_at < 0) ? 10 * DIV : abort_at;
    if (abort_at < 0) begin
      ev_kind[st + STOP_OFS] = stop ? 1 : 2;
      ev_byte[st + STOP_OFS] = d;
    end
    for (int i = 0; i < n; i++) begin
      rx_i = bits[i / DIV];
      @(negedge clk);
    end
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(fifo_empty_o), 32'd1);
    check({tag, "_full"}, 32'(fifo_full_o), 32'd0);
    check({tag, "_data"}, 32'(data_o), 32'h00);
    check({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
    check({tag, "_ovr"}, 32'(overrun_o), 32'd0);
  endtask

  initial begin
    int st;
    int f0;
    int o0;
    rx_i    = 1'b1;
    rd_en_i = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5: byte appears exactly one cycle after the stop sample.
    st = cyc;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        wait_cyc(st + STOP_OFS);
        check("a5_before_stop_empty", 32'(fifo_empty_o), 32'd1);
        wait_cyc(st + STOP_OFS + 1);
        check("a5_after_stop_empty", 32'(fifo_empty_o), 32'd0);
        check("a5_after_stop_data", 32'(data_o), 32'hA5);
      end
    join
    repeat (5) @(negedge clk);
    pop();
    check("a5_popped_empty", 32'(fifo_empty_o), 32'd1);

    // 3-cycle glitch is a false start.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_empty", 32'(fifo_empty_o), 32'd1);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_ovr", 32'(ovr_cnt - o0), 32'd0);

    // Bad stop bit then held low: one framing error, nothing queued.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1);
    repeat (30) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("break_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("break_empty", 32'(fifo_empty_o), 32'd1);
    send_frame(8'h01, 1'b1, -1);
    repeat (3) @(negedge clk);
    check("after_break_data", 32'(data_o), 32'h01);
    pop();
    check("after_break_empty", 32'(fifo_empty_o), 32'd1);

    // Five back-to-back frames, no reads: fifth overruns.
    o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, -1);
      if (i == 3) check("full_after_4th", 32'(fifo_full_o), 32'd1);
    end
    repeat (3) @(negedge clk);
    check("overrun_count", 32'(ovr_cnt - o0), 32'd1);
    check("still_full", 32'(fifo_full_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("ovr_read_order", 32'(data_o), 32'h10 + 32'(k));
      pop();
    end
    check("ovr_drained", 32'(fifo_empty_o), 32'd1);

    // Full FIFO with a pop on the write cycle: both succeed, no overrun.
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1, -1);
    o0 = ovr_cnt;
    st = cyc;
    fork
      send_frame(8'h24, 1'b1, -1);
      begin
        wait_cyc(st + STOP_OFS);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("simul_full", 32'(fifo_full_o), 32'd1);
    check("simul_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("simul_read_order", 32'(data_o), 32'h21 + 32'(k));
      pop();
    end
    check("simul_drained", 32'(fifo_empty_o), 32'd1);

    // Reset during data bit 4 with two bytes queued.
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hAA, 1'b1, -1);
    send_frame(8'h99, 1'b1, 4 * DIV + DIV + 4);
    check("pre_reset_empty", 32'(fifo_empty_o), 32'd0);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midframe");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h7E, 1'b1, -1);
    repeat (3) @(negedge clk);
    check("post_reset_empty", 32'(fifo_empty_o), 32'd0);
    check("post_reset_data", 32'(data_o), 32'h7E);
    pop();
    check("post_reset_drained", 32'(fifo_empty_o), 32'd1);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the existing `UartTx`. It samples an asynchronous 8N1 serial line, reassembles bytes, and buffers them in a small FIFO for a consumer in the `clk` domain. The first use is the bench-side control/loopback path on the Cmod S7 (`pio` pin in, bytes to the ADC test logic). It matches `UartTx` in baud, frame format and FIFO sizing so the two can be looped back pin-to-pin.

## Interface
Parameters:
- `CLK_FREQ`, default 87.49091e6 (real): `clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_ADDR_BITS`, default 2: FIFO depth is 2**FIFO_ADDR_BITS entries.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  serial line, asynchronous, idle high.
- `rd_en_i`  in  1  pop FIFO head; ignored when empty.
- `data_o`  out  8  FIFO head, first-word-fall-through; valid while `fifo_empty_o`=0.
- `fifo_empty_o`  out  1  FIFO holds no bytes.
- `fifo_full_o`  out  1  FIFO holds 2**FIFO_ADDR_BITS bytes.
- `frame_err_o`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun_o`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rx_i` passes through a 2-flop synchroniser; reset value of both flops is 1. All logic uses the synchronised line `rxs`.
- DIV = round(CLK_FREQ/BAUD), HALF = DIV/2 (floor). Both are computed at elaboration. The bit counter is $clog2(DIV) bits wide.
- FSM states:
  - IDLE: on `rxs`=0, clear the counter and go to START.
  - START: at count HALF-1, sample `rxs`. If it is 1, treat it as a false start and return to IDLE. Otherwise clear the counter and go to DATA.
  - DATA: at each count DIV-1, sample one bit, LSB first, into the shift register. After 8 bits go to STOP.
  - STOP: at count DIV-1, sample `rxs`.
    - If 1, write the byte to the FIFO when not full, otherwise pulse `overrun_o`. Go to IDLE.
    - If 0, pulse `frame_err_o`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line produces exactly one `frame_err_o`.
- FIFO:
  - A write occurs when STOP samples 1 and the FIFO is not full.
  - A read occurs when `rd_en_i`=1 and the FIFO is not empty.
  - Simultaneous read and write is legal in every state. When full, both succeed and the FIFO stays full.
  - Pointers are FIFO_ADDR_BITS+1 bits wide and wrap naturally. Full and empty are decoded from the pointer MSB and the remaining bits.
- Reset values:
  - `fifo_empty_o`=1, `fifo_full_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - `data_o`=0x00 (storage reset). FSM in IDLE, pointers 0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. After release the receiver waits for the next falling edge. A line already low at release is taken as a start and qualified by the START check.

## Timing
- T0 is the first `clk` edge at which `rxs`=0 in IDLE. `rx_i` leads `rxs` by 2 cycles.
- Start-bit check: T0+HALF. Data bit k sample: T0+HALF+(k+1)·DIV. Stop sample: T0+HALF+9·DIV.
- The FIFO write and the error pulses are registered on the stop-sample edge. `fifo_empty_o` falls and `data_o` is valid on the following cycle.
- A pop on edge E presents the next head or asserts `fifo_empty_o` after E. There is zero-cycle read latency (FWFT).
- The receiver is back in IDLE on the stop-sample edge, so back-to-back frames with one stop bit are received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - the `UART_DATA_BITS`=8 constant;
  - the DIV/HALF helper function, shared with `UartTx`.
- One sub-module, `uart_rx_fifo`: a parameterised FWFT synchronous FIFO with `clk`/`rst_n`. It is reusable by the transmit side.

## Test plan
Use CLK_FREQ=1e6, BAUD=100000, so DIV=10 and HALF=5; FIFO_ADDR_BITS=2.
- Frame 0xA5 with a good stop bit: on the cycle after the stop sample, `fifo_empty_o`=0 and `data_o`=0xA5. After one `rd_en_i`, `fifo_empty_o`=1.
- A 3-cycle low glitch on `rx_i`, line otherwise idle: no FIFO write and no error pulse; the FSM returns to IDLE.
- Frame 0x3C with stop bit 0, line then held low for 30 cycles: exactly one `frame_err_o` pulse, FIFO stays empty. A next good frame 0x01 is received correctly.
- Five back-to-back frames 0x10..0x14 with no reads:
  - `fifo_full_o`=1 after the 4th frame;
  - one `overrun_o` pulse at the 5th stop sample;
  - reads return 0x10, 0x11, 0x12, 0x13.
- FIFO full, with `rd_en_i` asserted on the cycle of a new write: the FIFO stays full, the head advances, and the new byte appears last in read order. No overrun pulse.
- `rst_n` pulsed low during bit 4 of a frame, with 2 bytes in the FIFO: all outputs return to their reset values. The next frame 0x7E is received correctly.
